// File: rtl/fifo_push_arb.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers.
// Optional burst lock (up to BURST_LEN back-to-back grants per owner) when FIFO_ARB_BURST_EN is defined.
module fifo_push_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      fifo_full_i,
    output logic                      fifo_push_o,
    output logic [ID_W+DATA_W-1:0]    fifo_push_data_o,
    output logic [ID_W-1:0]           grant_id_o,
    output logic [ID_W-1:0]           dbg_rr_ptr_o,
    output logic                      dbg_lock_o
);

    // Handshake: requester k transfers in a cycle where req_valid_i[k] & req_ready_o[k];
    // ready is decided combinationally every cycle, so it never waits on a prior ready.

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1) return '0;
        return id + 1'b1;
    endfunction

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_next;
    logic            scan_hit;
    logic [ID_W-1:0] scan_id;
    logic            grant;
    logic [ID_W-1:0] gnt_id;
    int              slot;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        scan_hit = 1'b0;
        scan_id  = '0;
        slot     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = int'(rr_ptr) + i;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
            if (!scan_hit && req_valid_i[slot]) begin
                scan_hit = 1'b1;
                scan_id  = ID_W'(slot);
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  owner_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        count_next  = count;
        rr_ptr_next = rr_ptr;
        grant       = 1'b0;
        gnt_id      = scan_id;
        case (state)
            IDLE: begin
                grant = scan_hit & ~fifo_full_i;
                if (grant) begin
                    if (BURST_LEN > 1) begin
                        state_next = LOCK;
                        owner_next = scan_id;
                        count_next = CNT_W'(1);
                    end else begin
                        rr_ptr_next = next_id(scan_id);
                    end
                end
            end
            LOCK: begin
                gnt_id = owner;
                if (!req_valid_i[owner]) begin
                    // Owner went quiet: give up the lock after a single bubble.
                    state_next  = IDLE;
                    count_next  = '0;
                    rr_ptr_next = next_id(owner);
                end else if (!fifo_full_i) begin
                    grant = 1'b1;
                    if (count == CNT_W'(BURST_LEN - 1)) begin
                        state_next  = IDLE;
                        count_next  = '0;
                        rr_ptr_next = next_id(owner);
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            count  <= count_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    assign dbg_lock_o = (state == LOCK);
`else
    always_comb begin
        grant       = scan_hit & ~fifo_full_i;
        gnt_id      = scan_id;
        rr_ptr_next = grant ? next_id(scan_id) : rr_ptr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rr_ptr <= '0;
        else       rr_ptr <= rr_ptr_next;
    end

    assign dbg_lock_o = 1'b0;

    // BURST_LEN has no effect without the burst lock.
    if (BURST_LEN < 1) begin : g_burst_len_inert
    end
`endif

    assign dbg_rr_ptr_o = rr_ptr;

    // Outputs are held at zero for the whole time reset is high.
    always_comb begin
        req_ready_o      = '0;
        fifo_push_o      = 1'b0;
        grant_id_o       = '0;
        fifo_push_data_o = '0;
        if (grant && !reset) begin
            req_ready_o[gnt_id] = 1'b1;
            fifo_push_o         = 1'b1;
            grant_id_o          = gnt_id;
            fifo_push_data_o    = {gnt_id, req_data_i[int'(gnt_id)*DATA_W +: DATA_W]};
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Bench for fifo_push_arb: vector table with a push scoreboard, reset-in-flight sequence,
// and a random phase against a small FIFO model. Burst-lock vectors apply when FIFO_ARB_BURST_EN is defined.
module tb_fifo_push_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;
    localparam int W       = ID_W + DATA_W;
    localparam int DEPTH   = 4;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_push;
    logic [W-1:0]              fifo_push_data;
    logic [ID_W-1:0]           grant_id;
    logic [ID_W-1:0]           dbg_ptr;
    logic                      dbg_lock;

    fifo_push_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_LEN(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid_i      (req_valid),
        .req_data_i       (req_data),
        .req_ready_o      (req_ready),
        .fifo_full_i      (fifo_full),
        .fifo_push_o      (fifo_push),
        .fifo_push_data_o (fifo_push_data),
        .grant_id_o       (grant_id),
        .dbg_rr_ptr_o     (dbg_ptr),
        .dbg_lock_o       (dbg_lock)
    );

    // Clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic               full;
        logic               exp_push;
        logic [ID_W-1:0]    exp_id;
        logic [ID_W-1:0]    exp_ptr;
        logic               exp_lock;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] fifo_q[$];
    logic [DATA_W-1:0] d[NUM_REQ];
    int checks   = 0;
    int failures = 0;

    function automatic void add_vec(input logic [3:0] valid, input logic full, input logic push,
                                    input logic [1:0] id, input logic [1:0] ptr, input logic lock);
        vec_t v;
        v.valid = valid; v.full = full; v.exp_push = push;
        v.exp_id = id; v.exp_ptr = ptr; v.exp_lock = lock;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver
    task automatic apply_inputs(input logic [NUM_REQ-1:0] valid, input logic full);
        req_valid = valid;
        fifo_full = full;
        for (int k = 0; k < NUM_REQ; k++) begin
            d[k] = DATA_W'($urandom_range(0, 255));
            req_data[k*DATA_W +: DATA_W] = d[k];
        end
    endtask

    // Scoreboard: one expected word per cycle a push is predicted
    task automatic check_push_sb(input string name);
        logic [W-1:0] exp_w;
        if (fifo_push) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected_push: got %0h expected no push", name, fifo_push_data);
            end else begin
                exp_w = exp_q.pop_front();
                chk({name, "_data"}, 32'(fifo_push_data), 32'(exp_w));
            end
        end else if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s_missing_push: got no push expected %0h", name, exp_w);
        end
    endtask

    initial begin
        logic         pend;
        logic [W-1:0] pend_w;
        logic         full_now;

        reset = 1'b1;
        apply_inputs('1, 1'b0);

`ifdef FIFO_ARB_BURST_EN
        for (int i = 0; i < 4; i++) add_vec(4'b1111, 0, 1, 2'd0, 2'd0, i != 0);
        for (int i = 0; i < 4; i++) add_vec(4'b1111, 0, 1, 2'd1, 2'd1, i != 0);
        add_vec(4'b1111, 0, 1, 2'd2, 2'd2, 0);
        add_vec(4'b1111, 0, 1, 2'd2, 2'd2, 1);
        add_vec(4'b1111, 1, 0, 2'd0, 2'd2, 1);
        add_vec(4'b1011, 0, 0, 2'd0, 2'd2, 1);
        add_vec(4'b1011, 0, 1, 2'd3, 2'd3, 0);
`else
        for (int i = 0; i < 8; i++) add_vec(4'b1111, 0, 1, 2'(i % 4), 2'(i % 4), 0);
        add_vec(4'b0010, 0, 1, 2'd1, 2'd0, 0);
        add_vec(4'b1010, 0, 1, 2'd3, 2'd2, 0);
        add_vec(4'b1010, 0, 1, 2'd1, 2'd0, 0);
        add_vec(4'b1010, 0, 1, 2'd3, 2'd2, 0);
        add_vec(4'b1111, 1, 0, 2'd0, 2'd0, 0);
        add_vec(4'b0100, 1, 0, 2'd0, 2'd0, 0);
        add_vec(4'b0000, 0, 0, 2'd0, 2'd0, 0);
        add_vec(4'b1110, 0, 1, 2'd1, 2'd0, 0);
        add_vec(4'b1111, 1, 0, 2'd0, 2'd2, 0);
        add_vec(4'b1111, 0, 1, 2'd2, 2'd2, 0);
        add_vec(4'b0001, 0, 1, 2'd0, 2'd3, 0);
        add_vec(4'b0001, 0, 1, 2'd0, 2'd1, 0);
`endif

        // Reset with every requester valid
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_push", 32'(fifo_push), 0);
        chk("rst_id", 32'(grant_id), 0);
        chk("rst_data", 32'(fifo_push_data), 0);
        chk("rst_ptr", 32'(dbg_ptr), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        apply_inputs('0, 1'b0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock); #1;
            apply_inputs(vecs[i].valid, vecs[i].full);
            if (vecs[i].exp_push) exp_q.push_back({vecs[i].exp_id, d[vecs[i].exp_id]});
            @(negedge clock);
            chk($sformatf("v%0d_push", i), 32'(fifo_push), 32'(vecs[i].exp_push));
            chk($sformatf("v%0d_id", i), 32'(grant_id), vecs[i].exp_push ? 32'(vecs[i].exp_id) : 0);
            chk($sformatf("v%0d_ready", i), 32'(req_ready),
                vecs[i].exp_push ? (32'(1) << vecs[i].exp_id) : 0);
            chk($sformatf("v%0d_ptr", i), 32'(dbg_ptr), 32'(vecs[i].exp_ptr));
            chk($sformatf("v%0d_lock", i), 32'(dbg_lock), 32'(vecs[i].exp_lock));
            check_push_sb($sformatf("v%0d", i));
        end

        // Reset in flight (mid-lock in the burst build), then restart from requester 0
        @(posedge clock); #1;
        reset = 1'b1;
        apply_inputs(4'b1111, 1'b0);
        @(negedge clock);
        chk("midrst_ready", 32'(req_ready), 0);
        chk("midrst_push", 32'(fifo_push), 0);
        chk("midrst_id", 32'(grant_id), 0);
        chk("midrst_data", 32'(fifo_push_data), 0);
        chk("midrst_lock", 32'(dbg_lock), 0);
        chk("midrst_ptr", 32'(dbg_ptr), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        apply_inputs(4'b1111, 1'b0);
        exp_q.push_back({2'd0, d[0]});
        @(negedge clock);
        chk("postrst_push", 32'(fifo_push), 1);
        chk("postrst_id", 32'(grant_id), 0);
        chk("postrst_ready", 32'(req_ready), 1);
        chk("postrst_lock", 32'(dbg_lock), 0);
        check_push_sb("postrst");

        // Random traffic against a small FIFO whose full flag updates after the edge
        pend   = 1'b0;
        pend_w = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            if (pend) fifo_q.push_back(pend_w);
            if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) fifo_q.pop_front();
            full_now = (fifo_q.size() >= DEPTH);
            apply_inputs(NUM_REQ'($urandom_range(0, 15)), full_now);
            @(negedge clock);
            chk("rnd_no_push_when_full", 32'(fifo_push & fifo_full), 0);
            chk("rnd_ready_vs_push", 32'(|req_ready), 32'(fifo_push));
            if (fifo_push) begin
                chk("rnd_ready_onehot", 32'(req_ready), 32'(1) << grant_id);
                chk("rnd_ready_valid", 32'(req_ready & ~req_valid), 0);
                chk("rnd_payload", 32'(fifo_push_data), 32'({grant_id, d[grant_id]}));
            end else begin
                chk("rnd_idle_id", 32'(grant_id), 0);
            end
`ifndef FIFO_ARB_BURST_EN
            chk("rnd_work_conserving", 32'(fifo_push), 32'((|req_valid) & ~fifo_full));
`endif
            pend   = fifo_push;
            pend_w = fifo_push_data;
        end

        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
